odl_gnt_pipe: RTL and testbench
===============================

Name: ODL_gnt_pipe

Overview:
- Port-side front end for the weighted round-robin arbiter.
- Collects NUM_PORT valid/ready request streams and presents a request vector to the arbiter.
- Consumes the arbiter's one-hot grant in the same cycle and moves the granted port's beat into a 2-entry output skid buffer that drives a single valid/ready master stream.
- Adds packet locking, so a multi-beat packet is never interleaved, and back-pressure gating, so arbiter weight is only spent on beats actually accepted.

Parameters:
- NUM_PORT, 8, number of requesting ports (>=2).
- DATA_W, 32, payload width per beat.
- IDX_W, $clog2(NUM_PORT), localparam, source index width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- s_valid_i  in  NUM_PORT  per-port beat valid.
- s_data_i  in  DATA_W x NUM_PORT  per-port payload (unpacked array [NUM_PORT-1:0]).
- s_last_i  in  NUM_PORT  per-port end-of-packet flag.
- s_ready_o  out  NUM_PORT  per-port accept; one-hot or zero.
- arb_req_o  out  NUM_PORT  request vector to arbiter.
- arb_gnt_i  in  NUM_PORT  one-hot grant from arbiter, combinational response to arb_req_o.
- m_valid_o  out  1  output beat valid.
- m_data_o  out  DATA_W  output payload.
- m_last_o  out  1  output end-of-packet.
- m_src_o  out  IDX_W  source port index of the output beat.
- m_ready_i  in  1  downstream accept.
- err_o  out  1  sticky grant-protocol error (see Optional Feature).

Behaviour:
- Reset (rst_i=1 at a clk_i edge): buffer count=0, lock cleared, err_o=0. Resulting outputs: m_valid_o=0, m_data_o=0, m_last_o=0, m_src_o=0, s_ready_o=0, arb_req_o=0. Reset mid-packet discards buffered beats and the lock.
- can_acc = (count<2). It depends on registered state only; no combinational path from m_ready_i to arb_req_o.
- Unlocked: arb_req_o = s_valid_i & {NUM_PORT{can_acc}}.
- Locked to port L: arb_req_o = s_valid_i & onehot(L) & {NUM_PORT{can_acc}}.
- s_ready_o = arb_gnt_i & arb_req_o. A beat transfers from port i when s_valid_i[i] & s_ready_o[i].
- Accepted beat: {data, last, i} is written to the buffer tail. It appears on m_* one cycle after acceptance if the buffer was empty (latency 1).
- Lock FSM, states UNLOCK and LOCK(L):
  - UNLOCK -> LOCK(i) on an accepted beat with last=0.
  - LOCK(L) -> UNLOCK on an accepted beat from L with last=1.
  - A single-beat packet (last=1 on the first beat) never locks.
- Skid buffer: 2 entries, head/tail pointers, count 0..2.
  - Output pop when m_valid_o & m_ready_i.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Full (count=2): no requests issued; the arbiter sees arb_req_o=0 and resets its pointer, which is accepted behaviour.
  - Sustained throughput is 1 beat/cycle while m_ready_i=1.
- m_* are registered from the head entry and stay stable while m_valid_o=1 & m_ready_i=0.
- Grant to a port not in arb_req_o: ignored (no transfer). With more than one grant bit set, the lowest-index granted, requesting port is taken.

Optional Feature:
- Macro ODL_GNT_PIPE_CHECK_EN.
- Defined: err_o is set and held until reset when, in any cycle, arb_gnt_i is not one-hot-or-zero, or arb_gnt_i & ~arb_req_o is nonzero, or (arb_req_o!=0 & arb_gnt_i==0). A simulation-only assertion fires on the same conditions.
- Undefined: err_o is tied to 0, with no check logic.

Test Plan:
- Reset with all s_valid_i=1 -> all outputs 0 during reset. First accept on the cycle after deassertion; m_valid_o=1 one cycle later.
- Ports 0 and 3 valid single-beat streams, arbiter weights 2 and 1, m_ready_i=1 -> m_src_o sequence 0,0,3,0,0,3 at one beat per cycle.
- Port 2 sends a 4-beat packet (last on beat 4) while port 5 is continuously valid -> arb_req_o=0b00000100 for beats 2-4. All four port-2 beats are contiguous on m_*, then port 5.
- m_ready_i=0 for 5 cycles with port 1 valid -> exactly 2 beats accepted, arb_req_o=0 while count=2, m_data_o held stable. After m_ready_i=1, no beat is lost or duplicated.
- rst_i asserted after beat 2 of a 4-beat packet from port 6 -> lock and buffer cleared. Port 0 can then win immediately.
- With ODL_GNT_PIPE_CHECK_EN, force arb_gnt_i=0b00000011 -> err_o=1 the next cycle and stays 1 until reset. Without the macro, err_o stays 0.

Source files
------------

// File: rtl/odl_gnt_pipe.sv
// Port-side front end for the weighted round-robin arbiter: packet lock, back-pressure gated
// requests and a 2-entry output skid buffer. Grant checker enabled by `define ODL_GNT_PIPE_CHECK_EN.
module odl_gnt_pipe #(
    parameter int  NUM_PORT = 8,
    parameter int  DATA_W   = 32,
    localparam int IDX_W    = $clog2(NUM_PORT)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_PORT-1:0] s_valid_i,
    input  logic [DATA_W-1:0]   s_data_i [NUM_PORT-1:0],
    input  logic [NUM_PORT-1:0] s_last_i,
    output logic [NUM_PORT-1:0] s_ready_o,
    output logic [NUM_PORT-1:0] arb_req_o,
    input  logic [NUM_PORT-1:0] arb_gnt_i,
    output logic                m_valid_o,
    output logic [DATA_W-1:0]   m_data_o,
    output logic                m_last_o,
    output logic [IDX_W-1:0]    m_src_o,
    input  logic                m_ready_i,
    output logic                err_o
);

    // state  | meaning
    // UNLOCK | between packets, every valid port may request
    // LOCK   | mid-packet, only port lock_idx_q may request
    typedef enum logic {UNLOCK, LOCK} lock_e;

    lock_e             state_q, state_d;
    logic [IDX_W-1:0]  lock_idx_q, lock_idx_d;

    logic [DATA_W-1:0] buf_data_q [0:1];
    logic [IDX_W-1:0]  buf_src_q  [0:1];
    logic [1:0]        buf_last_q;
    logic              head_q, tail_q;
    logic [1:0]        count_q;

    logic              can_acc;
    logic [NUM_PORT-1:0] lock_mask;
    logic [NUM_PORT-1:0] gnt_req;
    logic [NUM_PORT-1:0] sel;
    logic [IDX_W-1:0]  push_idx;
    logic              push, pop;

    // Only registered occupancy feeds the request, so m_ready_i never reaches arb_req_o.
    assign can_acc = (count_q != 2'd2);

    always_comb begin
        lock_mask = '1;
        if (state_q == LOCK) begin
            lock_mask = '0;
            lock_mask[lock_idx_q] = 1'b1;
        end
    end

    assign arb_req_o = s_valid_i & lock_mask & {NUM_PORT{can_acc & ~rst_i}};
    assign gnt_req   = arb_gnt_i & arb_req_o;

    always_comb begin
        sel      = '0;
        push_idx = '0;
        for (int i = NUM_PORT - 1; i >= 0; i--) begin
            if (gnt_req[i]) begin
                sel      = '0;
                sel[i]   = 1'b1;
                push_idx = IDX_W'(i);
            end
        end
    end

    assign s_ready_o = sel;
    assign push      = |sel;
    assign pop       = m_valid_o & m_ready_i;

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        case (state_q)
            UNLOCK: begin
                if (push && !s_last_i[push_idx]) begin
                    state_d    = LOCK;
                    lock_idx_d = push_idx;
                end
            end
            LOCK: begin
                if (push && s_last_i[push_idx]) begin
                    state_d = UNLOCK;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= UNLOCK;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            count_q    <= 2'd0;
            buf_last_q <= '0;
            for (int e = 0; e < 2; e++) begin
                buf_data_q[e] <= '0;
                buf_src_q[e]  <= '0;
            end
        end else begin
            if (push) begin
                buf_data_q[tail_q] <= s_data_i[push_idx];
                buf_last_q[tail_q] <= s_last_i[push_idx];
                buf_src_q[tail_q]  <= push_idx;
                tail_q             <= ~tail_q;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign m_valid_o = (count_q != 2'd0);
    assign m_data_o  = buf_data_q[head_q];
    assign m_last_o  = buf_last_q[head_q];
    assign m_src_o   = buf_src_q[head_q];

`ifdef ODL_GNT_PIPE_CHECK_EN
    logic gnt_bad;
    logic err_q;

    assign gnt_bad = ((arb_gnt_i & (arb_gnt_i - NUM_PORT'(1))) != '0)
                   | ((arb_gnt_i & ~arb_req_o) != '0)
                   | ((arb_req_o != '0) & (arb_gnt_i == '0));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (gnt_bad) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

`ifndef SYNTHESIS
    a_gnt_ok: assert property (@(posedge clk_i) disable iff (rst_i) !gnt_bad);
`endif
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_odl_gnt_pipe.sv
// Scoreboard bench for odl_gnt_pipe: WRR arbiter and packet/lock/occupancy model drive the DUT,
// a monitor process compares every presented output beat against the expected queue.
`timescale 1ns/1ps
module tb_odl_gnt_pipe;
    localparam int NP = 8;
    localparam int DW = 32;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] s_valid = '0, s_last = '0, s_ready, arb_req, arb_gnt = '0;
    logic [DW-1:0] s_data [NP-1:0];
    logic          m_valid, m_last, m_ready = 1'b1, err;
    logic [DW-1:0] m_data;
    logic [IW-1:0] m_src;

    always #5 clk = ~clk;

    odl_gnt_pipe #(.NUM_PORT(NP), .DATA_W(DW)) dut (
        .clk_i(clk), .rst_i(rst),
        .s_valid_i(s_valid), .s_data_i(s_data), .s_last_i(s_last), .s_ready_o(s_ready),
        .arb_req_o(arb_req), .arb_gnt_i(arb_gnt),
        .m_valid_o(m_valid), .m_data_o(m_data), .m_last_o(m_last), .m_src_o(m_src),
        .m_ready_i(m_ready), .err_o(err)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic [IW-1:0] s;
    } beat_t;

    beat_t exp_q[$];
    int    src_log[$];
    int    n_cmp = 0, n_bad = 0;

    int    wt[NP], pkt_len[NP], beat_no[NP];
    int    rr_ptr = 0, rr_cnt = 0;
    bit    mdl_lock = 0;
    int    mdl_lp = 0;
    bit    mon_en = 0, force_en = 0, rand_len = 0;
    logic [NP-1:0] force_gnt = '0, req_seen;
    logic  exp_err = 1'b0;
    int    acc_cnt = 0, last_acc = -1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    function automatic logic [NP-1:0] onehot(input int p);
        logic [NP-1:0] r;
        r = '0;
        r[p] = 1'b1;
        return r;
    endfunction

    // WRR arbiter: first requester at or after the pointer wins.
    function automatic logic [NP-1:0] wrr_gnt(input logic [NP-1:0] req);
        for (int k = 0; k < NP; k++) begin
            if (req[(rr_ptr + k) % NP]) return onehot((rr_ptr + k) % NP);
        end
        return '0;
    endfunction

    task automatic wrr_update(input int a);
        if (a == rr_ptr) rr_cnt++;
        else begin
            rr_ptr = a;
            rr_cnt = 1;
        end
        if (rr_cnt >= wt[a]) begin
            rr_ptr = (a + 1) % NP;
            rr_cnt = 0;
        end
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic drive(input logic [NP-1:0] v, input logic mr);
        logic [NP-1:0] exp_req, exp_rdy, hit;
        beat_t b;
        int a;
        m_ready = mr;
        for (int i = 0; i < NP; i++) begin
            s_valid[i] = v[i];
            s_data[i]  = $urandom;
            s_last[i]  = (beat_no[i] + 1 >= pkt_len[i]);
        end
        exp_req = (exp_q.size() < 2) ? v : '0;
        if (mdl_lock) exp_req = exp_req & onehot(mdl_lp);
        arb_gnt = force_en ? force_gnt : wrr_gnt(exp_req);
        hit = arb_gnt & exp_req;
        a = -1;
        for (int i = NP - 1; i >= 0; i--) if (hit[i]) a = i;
        exp_rdy = (a >= 0) ? onehot(a) : '0;
        #1;
        req_seen = arb_req;
        chk("arb_req", 64'(arb_req), 64'(exp_req));
        chk("s_ready", 64'(s_ready), 64'(exp_rdy));
        #2;
        if (a >= 0) begin
            b.d = s_data[a];
            b.l = s_last[a];
            b.s = IW'(a);
            exp_q.push_back(b);
            acc_cnt++;
            last_acc = a;
            if (!mdl_lock && !s_last[a]) begin
                mdl_lock = 1;
                mdl_lp   = a;
            end else if (mdl_lock && s_last[a]) begin
                mdl_lock = 0;
            end
            beat_no[a] = s_last[a] ? 0 : beat_no[a] + 1;
            if (s_last[a] && rand_len) pkt_len[a] = $urandom_range(1, 4);
            wrr_update(a);
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [NP-1:0] v);
        mon_en   = 0;
        force_en = 0;
        rst      = 1'b1;
        m_ready  = 1'b1;
        arb_gnt  = '0;
        s_valid  = v;
        @(posedge clk);
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_m_data",  64'(m_data),  64'(0));
        chk("rst_m_last",  64'(m_last),  64'(0));
        chk("rst_m_src",   64'(m_src),   64'(0));
        chk("rst_s_ready", 64'(s_ready), 64'(0));
        chk("rst_arb_req", 64'(arb_req), 64'(0));
        chk("rst_err",     64'(err),     64'(0));
        exp_err = 1'b0;
        @(negedge clk);
        exp_q.delete();
        src_log.delete();
        mdl_lock = 0;
        rr_ptr   = 0;
        rr_cnt   = 0;
        foreach (beat_no[i]) beat_no[i] = 0;
        rst    = 1'b0;
        mon_en = 1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            #2;
            chk("m_valid", 64'(m_valid), 64'(exp_q.size() != 0));
            if (m_valid && exp_q.size() != 0) begin
                chk("m_data", 64'(m_data), 64'(exp_q[0].d));
                chk("m_last", 64'(m_last), 64'(exp_q[0].l));
                chk("m_src",  64'(m_src),  64'(exp_q[0].s));
            end
            chk("err", 64'(err), 64'(exp_err));
            if (m_ready && exp_q.size() != 0) begin
                src_log.push_back(int'(m_src));
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, expected bench to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_seq[6];
        int acc0;
        logic [DW-1:0] held;
        exp_seq = '{0, 0, 3, 0, 0, 3};
        foreach (s_data[i]) s_data[i] = '0;
        foreach (wt[i]) begin
            wt[i] = 1;
            pkt_len[i] = 1;
            beat_no[i] = 0;
        end
        @(negedge clk);

        // Reset with all ports valid, then first accept right after release.
        do_reset('1);
        acc0 = acc_cnt;
        drive('1, 1'b1);
        chk("first_acc_cnt", 64'(acc_cnt - acc0), 64'(1));
        chk("first_acc_port", 64'(last_acc), 64'(0));
        chk("first_m_valid", 64'(m_valid), 64'(1));
        drive('0, 1'b1);

        // Weighted round robin 0:2, 3:1 at full throughput.
        do_reset('0);
        wt[0] = 2;
        wt[3] = 1;
        repeat (6) drive(8'b0000_1001, 1'b1);
        drive('0, 1'b1);
        chk("wrr_count", 64'(src_log.size()), 64'(6));
        for (int i = 0; i < 6; i++) begin
            if (i < src_log.size()) chk("wrr_seq", 64'(src_log[i]), 64'(exp_seq[i]));
        end
        wt[0] = 1;

        // Port 2 four-beat packet against continuously valid port 5.
        do_reset('0);
        pkt_len[2] = 4;
        for (int c = 0; c < 5; c++) begin
            drive(8'b0010_0100, 1'b1);
            if (c >= 1 && c <= 3) chk("lock_req", 64'(req_seen), 64'(8'b0000_0100));
        end
        drive('0, 1'b1);
        drive('0, 1'b1);
        chk("lock_count", 64'(src_log.size()), 64'(5));
        for (int i = 0; i < 5; i++) begin
            if (i < src_log.size()) chk("lock_seq", 64'(src_log[i]), 64'(i < 4 ? 2 : 5));
        end
        pkt_len[2] = 1;

        // Downstream stall with port 1 valid.
        do_reset('0);
        acc0 = acc_cnt;
        held = '0;
        for (int c = 0; c < 5; c++) begin
            drive(8'b0000_0010, 1'b0);
            if (c == 1) held = exp_q[0].d;
            if (c >= 2) chk("stall_req", 64'(req_seen), 64'(0));
        end
        chk("stall_acc", 64'(acc_cnt - acc0), 64'(2));
        chk("stall_hold", 64'(m_data), 64'(held));
        repeat (3) drive('0, 1'b1);
        chk("stall_drain", 64'(src_log.size()), 64'(2));
        chk("stall_empty", 64'(m_valid), 64'(0));

        // Reset in the middle of a port 6 packet.
        do_reset('0);
        pkt_len[6] = 4;
        repeat (2) drive(8'b0100_0000, 1'b1);
        do_reset(8'b0100_0001);
        drive(8'b0100_0001, 1'b1);
        chk("post_rst_winner", 64'(last_acc), 64'(0));
        drive('0, 1'b1);
        chk("post_rst_src", 64'(src_log.size() > 0 ? src_log[0] : -1), 64'(0));
        pkt_len[6] = 1;

        // Randomized traffic with random weights and packet lengths.
        do_reset('0);
        rand_len = 1;
        foreach (wt[i]) begin
            wt[i] = $urandom_range(1, 3);
            pkt_len[i] = $urandom_range(1, 4);
        end
        repeat (3000) drive(NP'($urandom), ($urandom_range(0, 3) != 0));
        mdl_lock = mdl_lock;
        repeat (4) drive('0, 1'b1);
        chk("rand_drained", 64'(exp_q.size()), 64'(0));
        rand_len = 0;
        foreach (pkt_len[i]) pkt_len[i] = 1;

        // Illegal double grant: lowest requesting port taken; err only with the checker.
        do_reset('0);
        force_en  = 1;
        force_gnt = 8'b0000_0011;
        drive(8'b0000_0011, 1'b1);
        force_en = 0;
        chk("multi_gnt_port", 64'(last_acc), 64'(0));
`ifdef ODL_GNT_PIPE_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        chk("err_set", 64'(err), 64'(exp_err));
        repeat (3) drive('0, 1'b1);
        chk("err_hold", 64'(err), 64'(exp_err));
        do_reset('0);
        chk("err_clr", 64'(err), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
